// File: rtl/imm_instr_encoder_loader_if.sv
// Request stream and instruction-memory write bus of the immediate encoder/loader.
// The producer of encode requests is the master; the loader is the slave.
interface imm_instr_encoder_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic              is_branch;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [31:0]       imm;
    logic              last;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, is_branch, opcode, rd, rs1, rs2, funct3, imm, last,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, is_branch, opcode, rd, rs1, rs2, funct3, imm, last,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/imm_instr_encoder_loader.sv
// Packs fields plus a signed 12-bit immediate into I-type or B-type words and
// writes them sequentially into instruction memory from a programmable base.
module imm_instr_encoder_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    imm_instr_encoder_loader_if.slave bus,
    output logic                busy,
    output logic                done,
    output logic                range_err,
    output logic [CNT_W-1:0]    count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] ptr_q,       ptr_d;
    logic [CNT_W-1:0]  count_q,     count_d;
    logic              in_ready_q,  in_ready_d;
    logic              busy_q,      busy_d;
    logic              done_q,      done_d;
    logic              range_err_q, range_err_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;

    logic              accept;
    logic              imm_legal;
    logic [31:0]       enc_word;

    assign accept = bus.in_valid & in_ready_q;

    // Fits in 12 signed bits iff the bits above the sign bit all copy it.
    assign imm_legal = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);

    always_comb begin
        if (bus.is_branch) begin
            enc_word = {bus.imm[11], bus.imm[9:4], bus.rs2, bus.rs1, bus.funct3,
                        bus.imm[3:0], bus.imm[10], bus.opcode};
        end else begin
            enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        end
    end

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned; that is what keeps this block free of latches.
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        done_d      = 1'b0;
        range_err_d = range_err_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = RUN;
                    ptr_d       = {base_addr[ADDR_W-1:2], 2'b00};
                    count_d     = '0;
                    range_err_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (accept) begin
                    if (imm_legal) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ptr_q;
                        mem_wdata_d = enc_word;
                        ptr_d       = ptr_q + ADDR_W'(4);
                        count_d     = (&count_q) ? count_q : count_q + CNT_W'(1);
                        if (bus.last) begin
                            state_d = FLUSH;
                            done_d  = 1'b1;
                        end
                    end else begin
                        // Abort: the offending request is dropped, nothing is written.
                        state_d     = DONE;
                        range_err_d = 1'b1;
                        done_d      = 1'b1;
                    end
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d = (state_d == RUN);
        busy_d     = (state_d == RUN) || (state_d == FLUSH);
    end

    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignment so every flop samples the
        // pre-edge value of the others, independent of statement order.
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            range_err_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            range_err_q <= range_err_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign range_err     = range_err_q;
    assign count         = count_q;

endmodule
